// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter_pkg
// Purpose : Shared constants and types for the CDB arbiter slice.
//           N_FU_CDB       - number of functional units driving the CDB
//           CDB_FIFO_DEPTH - per-FU result FIFO depth
//           fu_cdb_reg_t   - completed-result packet broadcast on the CDB
//           cdb_src_t      - index of the FU that sourced a CDB packet
// Revision: 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int N_FU_CDB       = 4;
    localparam int CDB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [5:0]  rob_id;
        logic [4:0]  rd_arch;
        logic [6:0]  rd_phy;
        logic [31:0] rd_value;
        logic [7:0]  dbg;
    } fu_cdb_reg_t;

    typedef logic [$clog2(N_FU_CDB)-1:0] cdb_src_t;

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_fu_fifo.sv
`default_nettype none
// ============================================================================
// Module  : cdb_fu_fifo
// Purpose : Synchronous FIFO holding one FU's completed results until the
//           CDB arbiter drains them. Flush empties it in one edge.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           flush      - empty the FIFO; overrides push and pop
//           push, din  - enqueue request and data (ignored when not ready)
//           pop        - dequeue request (ignored when empty)
//           head       - oldest entry
//           empty      - no entries
//           ready      - space available (derived from the count register)
// Revision: 1.0 - initial release
// ============================================================================
module cdb_fu_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  fu_cdb_reg_t din,
    input  logic        pop,
    output fu_cdb_reg_t head,
    output logic        empty,
    output logic        ready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    fu_cdb_reg_t        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign empty  = (r_cnt == '0);
    assign ready  = (r_cnt != c_cnt_w'(DEPTH));
    assign w_push = push && ready;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the count unchanged.
            r_cnt <= r_cnt + {{(c_cnt_w-1){1'b0}}, w_push}
                           - {{(c_cnt_w-1){1'b0}}, w_pop};
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : cdb_fu_fifo
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Purpose : Shares the single result CDB among N_FU functional units. Each FU
//           pushes into a private FIFO; a round-robin arbiter drains one
//           packet per cycle into registered CDB outputs.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           backend_flush   - squash all queued and in-flight results
//           fu_valid/ready  - per-FU handshake (ready depends on count only)
//           fu_pkt          - per-FU packet
//           cdb_valid/pkt   - registered CDB broadcast
//           cdb_src         - FU index that sourced cdb_pkt
// Config  : CDB_ARB_BR_PRIO_EN - when defined, FU 0 (branch) wins whenever it
//           has a request; round-robin covers FUs 1..N_FU-1 and a grant to
//           FU 0 does not move the round-robin pointer.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_FU       = N_FU_CDB,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         backend_flush,
    input  logic [N_FU-1:0]              fu_valid,
    output logic [N_FU-1:0]              fu_ready,
    input  fu_cdb_reg_t [N_FU-1:0]       fu_pkt,
    output logic                         cdb_valid,
    output fu_cdb_reg_t                  cdb_pkt,
    output logic [$clog2(N_FU)-1:0]      cdb_src
);

    localparam int                c_sw   = $clog2(N_FU);
    localparam logic [c_sw-1:0]   c_last = c_sw'(N_FU - 1);

    fu_cdb_reg_t       w_head [N_FU];
    logic [N_FU-1:0]   w_req;
    logic [N_FU-1:0]   w_req_rr;
    logic [N_FU-1:0]   w_pop;
    logic              w_gnt_vld;
    logic [c_sw-1:0]   w_gnt_idx;
    logic              w_rr_adv;

    logic              r_cdb_valid;
    fu_cdb_reg_t       r_cdb_pkt;
    logic [c_sw-1:0]   r_cdb_src;
    logic [c_sw-1:0]   r_rr_ptr;

    generate
        for (genvar i = 0; i < N_FU; i++) begin : g_fifo
            logic w_empty;
            cdb_fu_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .flush (backend_flush),
                .push  (fu_valid[i]),
                .din   (fu_pkt[i]),
                .pop   (w_pop[i]),
                .head  (w_head[i]),
                .empty (w_empty),
                .ready (fu_ready[i])
            );
            assign w_req[i] = !w_empty;
        end
    endgenerate

    // First request at or after r_rr_ptr, wrapping at N_FU.
    always_comb begin
        int              v_sum;
        logic [c_sw-1:0] v_idx;
        w_req_rr  = w_req;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_sum     = 0;
        v_idx     = '0;
`ifdef CDB_ARB_BR_PRIO_EN
        w_req_rr[0] = 1'b0;
`endif
        for (int k = 0; k < N_FU; k++) begin
            v_sum = (int'(r_rr_ptr) + k) % N_FU;
            v_idx = v_sum[c_sw-1:0];
            if (!w_gnt_vld && w_req_rr[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
        w_rr_adv = w_gnt_vld;
`ifdef CDB_ARB_BR_PRIO_EN
        if (w_req[0]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = '0;
            w_rr_adv  = 1'b0;
        end
`endif
    end

    // Pops during a flush are harmless: the FIFO gives flush priority.
    assign w_pop = w_gnt_vld ? ({{(N_FU-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_pkt   <= '0;
            r_cdb_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (backend_flush) begin
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_cdb_pkt <= w_head[w_gnt_idx];
                r_cdb_src <= w_gnt_idx;
            end
            if (w_rr_adv) begin
                r_rr_ptr <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_pkt   = r_cdb_pkt;
    assign cdb_src   = r_cdb_src;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Purpose : Directed self-checking bench for cdb_arbiter (N_FU=4, depth 2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                clk;
    logic                rst;
    logic                backend_flush;
    logic [3:0]          fu_valid;
    logic [3:0]          fu_ready;
    fu_cdb_reg_t [3:0]   fu_pkt;
    logic                cdb_valid;
    fu_cdb_reg_t         cdb_pkt;
    logic [1:0]          cdb_src;

    int n_tests;
    int n_fail;

    cdb_arbiter #(
        .N_FU       (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .backend_flush (backend_flush),
        .fu_valid      (fu_valid),
        .fu_ready      (fu_ready),
        .fu_pkt        (fu_pkt),
        .cdb_valid     (cdb_valid),
        .cdb_pkt       (cdb_pkt),
        .cdb_src       (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fu_cdb_reg_t mk(input int r);
        fu_cdb_reg_t p;
        logic [5:0]  rb;
        rb         = r[5:0];
        p.rob_id   = rb;
        p.rd_arch  = rb[4:0];
        p.rd_phy   = {1'b0, rb};
        p.rd_value = 32'hA000_0000 | {26'h0, rb};
        p.dbg      = 8'h5A;
        return p;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        backend_flush = 1'b0;
        fu_valid      = 4'h0;
        for (int i = 0; i < 4; i++) fu_pkt[i] = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Checks a CDB beat: valid, source and full packet.
    task automatic expect_beat(input string name, input int src, input int rob);
        n_tests++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'(src) || cdb_pkt !== mk(rob)) begin
            n_fail++;
            $display("FAIL %s: got valid=%b src=%0d rob=%0d, want valid=1 src=%0d rob=%0d",
                     name, cdb_valid, cdb_src, cdb_pkt.rob_id, src, rob);
        end
    endtask

    task automatic expect_idle(input string name);
        n_tests++;
        if (cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got cdb_valid=%b rob=%0d, want cdb_valid=0",
                     name, cdb_valid, cdb_pkt.rob_id);
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++;
        if (cdb_valid !== 1'b0 || cdb_pkt !== '0 || cdb_src !== 2'd0 || fu_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL reset: got valid=%b pkt=%h src=%0d ready=%b, want 0/0/0/1111",
                     cdb_valid, cdb_pkt, cdb_src, fu_ready);
        end
    endtask

    task automatic test_single;
        do_reset();
        fu_valid  = 4'b0100;
        fu_pkt[2] = mk(5);
        step();
        fu_valid = 4'h0;
        expect_idle("single_edge0");
        step();
        expect_beat("single_edge1", 2, 5);
        step();
        expect_idle("single_edge2");
    endtask

    task automatic test_all_four;
        do_reset();
        fu_valid = 4'hF;
        for (int i = 0; i < 4; i++) fu_pkt[i] = mk(10 + i);
        step();
        fu_valid = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_beat("all4_order", i, 10 + i);
        end
        step();
        expect_idle("all4_drained");
        // rr_ptr back at 0: FU0 beats FU3.
        fu_valid  = 4'b1001;
        fu_pkt[0] = mk(20);
        fu_pkt[3] = mk(23);
        step();
        fu_valid = 4'h0;
        step();
        expect_beat("all4_rr_wrap_a", 0, 20);
        step();
        expect_beat("all4_rr_wrap_b", 3, 23);
    endtask

    task automatic test_fairness;
        int         push_seq [4];
        int         exp_seq  [4];
        int         exp_src;
        logic [3:0] rdy;
        logic       saw_full;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_seq[i] = 0;
            exp_seq[i]  = 0;
        end
        exp_src  = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < 4; i++) fu_pkt[i] = mk(i * 16 + push_seq[i]);
            fu_valid = 4'hF;
            rdy      = fu_ready;
            step();
            for (int i = 0; i < 4; i++) if (rdy[i]) push_seq[i]++;
            if (c >= 1) begin
                expect_beat("fair_rotation", exp_src, exp_src * 16 + exp_seq[exp_src]);
                exp_seq[exp_src]++;
                exp_src = (exp_src + 1) % 4;
            end
            if (!fu_ready[1]) saw_full = 1'b1;
        end
        fu_valid = 4'h0;
        n_tests++;
        if (saw_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fair_ready1: got fu_ready[1] never low, want low once FIFO1 full");
        end
        for (int c = 0; c < 12; c++) begin
            step();
            if (cdb_valid === 1'b1) begin
                expect_beat("fair_drain", int'(cdb_src), int'(cdb_src) * 16 + exp_seq[cdb_src]);
                exp_seq[cdb_src]++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (exp_seq[i] != push_seq[i]) begin
                n_fail++;
                $display("FAIL fair_count fu%0d: got %0d packets out, want %0d",
                         i, exp_seq[i], push_seq[i]);
            end
        end
    endtask

    task automatic test_flush;
        do_reset();
        fu_valid = 4'hF;
        for (int i = 0; i < 4; i++) fu_pkt[i] = mk(10 + i);
        step();
        fu_valid  = 4'b0011;
        fu_pkt[0] = mk(20);
        fu_pkt[1] = mk(21);
        step();
        expect_beat("flush_pre", 0, 10);
        // Five packets queued now; flush with fresh pushes that must vanish.
        backend_flush = 1'b1;
        fu_valid      = 4'hF;
        for (int i = 0; i < 4; i++) fu_pkt[i] = mk(30 + i);
        step();
        backend_flush = 1'b0;
        fu_valid      = 4'h0;
        expect_idle("flush_valid");
        n_tests++;
        if (fu_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL flush_ready: got %b, want 1111", fu_ready);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            expect_idle("flush_no_leak");
        end
        // rr_ptr held at 1 through the flush: FU1 wins over FU0.
        fu_valid  = 4'b0011;
        fu_pkt[0] = mk(40);
        fu_pkt[1] = mk(41);
        step();
        fu_valid = 4'h0;
        step();
        expect_beat("flush_rr_a", 1, 41);
        step();
        expect_beat("flush_rr_b", 0, 40);
    endtask

    task automatic test_br_prio;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            fu_valid  = 4'b1001;
            fu_pkt[0] = mk(c);
            fu_pkt[3] = mk(48 + c);
            step();
`ifdef CDB_ARB_BR_PRIO_EN
            if (c >= 1) expect_beat("prio_fu0", 0, c - 1);
`else
            n_tests++;
            if (c >= 1 && c <= 6 && (cdb_valid !== 1'b1 || cdb_src !== ((c % 2 == 1) ? 2'd0 : 2'd3))) begin
                n_fail++;
                $display("FAIL rr_alternate c=%0d: got valid=%b src=%0d, want valid=1 src=%0d",
                         c, cdb_valid, cdb_src, (c % 2 == 1) ? 0 : 3);
            end
`endif
        end
        fu_valid = 4'h0;
`ifdef CDB_ARB_BR_PRIO_EN
        step();
        expect_beat("prio_fu0_last", 0, 7);
        step();
        expect_beat("prio_fu3_a", 3, 48);
        step();
        expect_beat("prio_fu3_b", 3, 49);
        step();
        expect_idle("prio_done");
`else
        for (int c = 0; c < 10; c++) step();
        expect_idle("rr_drained");
`endif
    endtask

    task automatic test_rst_mid;
        do_reset();
        fu_valid = 4'hF;
        for (int i = 0; i < 4; i++) fu_pkt[i] = mk(50 + i);
        step();
        fu_valid = 4'h0;
        step();
        expect_beat("rstmid_pre", 0, 50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (cdb_valid !== 1'b0 || cdb_pkt !== '0 || cdb_src !== 2'd0 || fu_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got valid=%b pkt=%h src=%0d ready=%b, want 0/0/0/1111",
                     cdb_valid, cdb_pkt, cdb_src, fu_ready);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            expect_idle("rstmid_no_leak");
        end
        // rr_ptr reset to 0: FU0 beats FU3.
        fu_valid  = 4'b1001;
        fu_pkt[0] = mk(60);
        fu_pkt[3] = mk(63);
        step();
        fu_valid = 4'h0;
        step();
        expect_beat("rstmid_rr_a", 0, 60);
        step();
        expect_beat("rstmid_rr_b", 3, 63);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        backend_flush = 1'b0;
        fu_valid      = 4'h0;
        for (int i = 0; i < 4; i++) fu_pkt[i] = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_flush();
        test_br_prio();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
